// File: rtl/if_pc_sel_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | Package    : if_pkg                                                        |
// | Description: Shared widths, branch opcode default and fetch-state encoding |
// |              for the IF-stage PC sequencer.                                |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package if_pkg;

    localparam int          PC_W          = 32;
    localparam int          INSTR_BYTES   = 4;
    localparam logic [5:0]  BR_OPCODE_DEF = 6'b000100;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        REDIR = 2'd3
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/if_pc_sel_unit_if.sv
// +----------------------------------------------------------------------------+
// | Interface  : if_pc_sel_unit_if                                             |
// | Description: Fetch-side bus between the PC sequencer (master) and the      |
// |              branch handler / IF-ID register (slave). IF_PERF_CNT_EN adds |
// |              the performance counter outputs.                              |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

interface if_pc_sel_unit_if;
    import if_pkg::*;

    logic [31:0]     instr_IF;
    logic            br_prediction;
    logic            branch_hazard_stall;
    logic            load_use_stall;
    logic            flush;
    logic [PC_W-1:0] pc_IF;
    logic [PC_W-1:0] pc_plus4_IF;
    logic            IFID_write_en;
    logic            IFID_flush;
    logic            br_valid_ID;
    logic [PC_W-1:0] alt_pc_ID;
`ifdef IF_PERF_CNT_EN
    logic [31:0]     flush_cnt;
    logic [31:0]     stall_cnt;
`endif

    modport master (
        input  instr_IF, br_prediction, branch_hazard_stall, load_use_stall, flush,
`ifdef IF_PERF_CNT_EN
        output flush_cnt, stall_cnt,
`endif
        output pc_IF, pc_plus4_IF, IFID_write_en, IFID_flush, br_valid_ID, alt_pc_ID
    );

    modport slave (
        output instr_IF, br_prediction, branch_hazard_stall, load_use_stall, flush,
`ifdef IF_PERF_CNT_EN
        input  flush_cnt, stall_cnt,
`endif
        input  pc_IF, pc_plus4_IF, IFID_write_en, IFID_flush, br_valid_ID, alt_pc_ID
    );

endinterface

`default_nettype wire

// File: rtl/if_pc_sel_unit_brnch_target_calc.sv
// +----------------------------------------------------------------------------+
// | Module     : if_brnch_target_calc                                          |
// | Description: Combinational conditional-branch detect and PC-relative       |
// |              target adder; kept standalone so a BTB can reuse it.          |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_brnch_target_calc
    import if_pkg::*;
#(
    parameter logic [5:0] BR_OPCODE = BR_OPCODE_DEF
) (
    input  wire logic            i_if_valid,
    input  wire logic [PC_W-1:0] i_pc,
    input  wire logic [31:0]     i_instr,
    output logic                 o_br,
    output logic [PC_W-1:0]      o_target
);

    logic [PC_W-1:0] w_offset;
    logic            w_unused;

    assign w_offset = {{14{i_instr[15]}}, i_instr[15:0], 2'b00};
    assign o_br     = i_if_valid && (i_instr[31:26] == BR_OPCODE);
    // Modulo-2^32 add: wrapping past the top of the address space is intended.
    assign o_target = i_pc + PC_W'(INSTR_BYTES) + w_offset;
    assign w_unused = &{1'b0, i_instr[25:16]};

endmodule

`default_nettype wire

// File: rtl/if_pc_sel_unit.sv
// +----------------------------------------------------------------------------+
// | Module     : if_pc_sel_unit                                                |
// | Description: IF-stage PC sequencer: sequential / predicted / hold /        |
// |              mispredict-recovery next-PC select and IF/ID control.         |
// |              Optional macro IF_PERF_CNT_EN adds flush/stall counters.      |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_pc_sel_unit
    import if_pkg::*;
#(
    parameter logic [PC_W-1:0] PC_RESET_VEC = 32'h0000_0000,
    parameter logic [5:0]      BR_OPCODE    = BR_OPCODE_DEF
) (
    input  wire logic         clk,
    input  wire logic         rst,
    if_pc_sel_unit_if.master  bus
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] r_alt_pc;
    logic            r_br_valid;
    logic            w_if_valid;
    logic            w_br_if;
    logic            w_stall;
    logic            w_flush_eff;
    logic            w_write_en;

    assign w_if_valid  = (r_state != BOOT);
    assign w_pc_plus4  = r_pc + PC_W'(INSTR_BYTES);
    assign w_stall     = bus.branch_hazard_stall | bus.load_use_stall;
    assign w_flush_eff = bus.flush & r_br_valid;
    assign w_write_en  = !w_stall | w_flush_eff;

    if_brnch_target_calc #(
        .BR_OPCODE (BR_OPCODE)
    ) u_target_calc (
        .i_if_valid (w_if_valid),
        .i_pc       (r_pc),
        .i_instr    (bus.instr_IF),
        .o_br       (w_br_if),
        .o_target   (w_target)
    );

    // Recovery outranks stall so a mispredict can never be held off.
    always_comb begin
        w_pc_nxt    = w_pc_plus4;
        w_state_nxt = RUN;
        if (w_flush_eff) begin
            w_pc_nxt = r_alt_pc;
        end else if (w_stall) begin
            w_pc_nxt = r_pc;
        end else if (w_br_if && bus.br_prediction) begin
            w_pc_nxt = w_target;
        end
        if (r_state != BOOT) begin
            if (w_flush_eff) begin
                w_state_nxt = REDIR;
            end else if (w_stall) begin
                w_state_nxt = HOLD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= BOOT;
            r_pc       <= PC_RESET_VEC;
            r_br_valid <= 1'b0;
            r_alt_pc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_flush_eff) begin
                r_br_valid <= 1'b0;
                r_alt_pc   <= '0;
            end else if (w_write_en) begin
                r_br_valid <= w_br_if;
                // Record the path not taken so ID can redirect in one cycle.
                r_alt_pc   <= !w_br_if           ? '0 :
                              bus.br_prediction  ? w_pc_plus4 : w_target;
            end
        end
    end

    assign bus.pc_IF         = r_pc;
    assign bus.pc_plus4_IF   = w_pc_plus4;
    assign bus.IFID_write_en = rst | w_write_en;
    assign bus.IFID_flush    = w_flush_eff | (r_state == BOOT);
    assign bus.br_valid_ID   = r_br_valid;
    assign bus.alt_pc_ID     = r_alt_pc;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_flush_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_flush_eff && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
            if ((r_state == HOLD) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign bus.flush_cnt = r_flush_cnt;
    assign bus.stall_cnt = r_stall_cnt;
`endif

`ifndef SYNTHESIS
    // The recovery cycle never holds a branch in ID, so a back-to-back flush cannot occur.
    a_no_flush_in_redir : assert property (@(posedge clk) disable iff (rst)
        (r_state == REDIR) |-> !r_br_valid);
`endif

endmodule

`default_nettype wire
